// File: rtl/bcd_decoder_seq.sv
// rtl/bcd_decoder_seq.sv - sequential BCD-to-binary decoder (reverse double-dabble)
// One shift-right / subtract-3 step per clock, valid/ready on both sides.
module bcd_decoder_seq #(
  parameter int N = 3,
  localparam int W = 3 * N + (N + 2) / 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4*N-1:0]   i_bcd,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [W-1:0]     o_bin,
  output logic             o_err,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4*N-1:0]   bcd_q, bcd_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [W-1:0]     obin_q, obin_d;
  logic             oerr_q, oerr_d;
  logic             ovalid_q, ovalid_d;

  logic [4*N-1:0]   sh_bcd, step_bcd;
  logic [W-1:0]     sh_bin;
  logic             in_invalid;

  // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3.
  always_comb begin
    {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
    step_bcd = sh_bcd;
    for (int k = 0; k < N; k++) begin
      if (sh_bcd[4*k+3]) begin
        step_bcd[4*k +: 4] = sh_bcd[4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    in_invalid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_bcd[4*k +: 4] > 4'd9) begin
        in_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    obin_d   = obin_q;
    oerr_d   = oerr_q;
    ovalid_d = ovalid_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bcd_d   = i_bcd;
          bin_d   = '0;
          cnt_d   = '0;
          err_d   = in_invalid;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bcd_d = step_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Result is registered on the last step so it appears together with o_valid.
          obin_d   = err_q ? '0 : sh_bin;
          oerr_d   = err_q;
          ovalid_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        ovalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      obin_q   <= '0;
      oerr_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      obin_q   <= obin_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == BUSY);
  assign o_bin   = obin_q;
  assign o_err   = oerr_q;
  assign o_valid = ovalid_q;

endmodule

// File: tb/tb_bcd_decoder_seq.sv
// tb/tb_bcd_decoder_seq.sv - scoreboard bench for bcd_decoder_seq (N=3 and N=4)
// Expected results come from a decimal-arithmetic reference model.
module tb_bcd_decoder_seq;

  localparam int W3 = 10;
  localparam int W4 = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [11:0] bcd3;
  logic        v3, rdy3, err3, ov3, ir3, busy3;
  logic [9:0]  bin3;
  logic [15:0] bcd4;
  logic        v4, rdy4, err4, ov4, ir4, busy4;
  logic [13:0] bin4;

  bcd_decoder_seq #(.N(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_bcd(bcd3), .i_valid(v3), .o_ready(rdy3),
    .o_bin(bin3), .o_err(err3), .o_valid(ov3), .i_ready(ir3), .o_busy(busy3)
  );

  bcd_decoder_seq #(.N(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_bcd(bcd4), .i_valid(v4), .o_ready(rdy4),
    .o_bin(bin4), .o_err(err4), .o_valid(ov4), .i_ready(ir4), .o_busy(busy4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of the digits; any nibble above 9 flags an error and zeroes the result.
  function automatic void model(input logic [15:0] b, input int n, output int val, output bit err);
    int p;
    int d;
    val = 0;
    err = 1'b0;
    p = 1;
    for (int k = 0; k < n; k++) begin
      d = int'((b >> (4 * k)) & 16'hF);
      if (d > 9) err = 1'b1;
      val += d * p;
      p *= 10;
    end
    if (err) val = 0;
  endfunction

  typedef struct {
    int bin;
    bit err;
    int acc;
  } exp_t;

  exp_t q[$];
  bit   rand_bp = 1'b0;

  task automatic send3(input logic [11:0] b, output int acc);
    int  v;
    bit  e;
    bit  ok;
    @(negedge clk);
    bcd3 = b;
    v3   = 1'b1;
    ok   = 1'b0;
    acc  = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rdy3) begin
        model({4'h0, b}, 3, v, e);
        acc = cyc + 1;
        q.push_back('{v, e, acc});
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic drop3();
    @(negedge clk);
    v3 = 1'b0;
  endtask

  task automatic drain3();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !ov3 && rdy3) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic run4(input logic [15:0] b);
    int v;
    bit e;
    int acc;
    bit ok;
    model(b, 4, v, e);
    @(negedge clk);
    bcd4 = b;
    v4   = 1'b1;
    ok   = 1'b0;
    acc  = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rdy4) begin
        acc = cyc + 1;
        ok  = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    v4 = 1'b0;
    if (!ok) check("accept4_timeout", 0, 1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (ov4) ok = 1'b1;
    end
    if (!ok) begin
      check("valid4_timeout", 0, 1);
    end else begin
      check("bin4", bin4, v);
      check("err4", err4, e);
      check("latency4", cyc - acc, W4);
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each new result, then checks the result is held.
  initial begin
    exp_t        e;
    bit          seen;
    logic [9:0]  held;
    logic        held_err;
    seen = 1'b0;
    held = '0;
    held_err = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        seen = 1'b0;
      end else if (ov3) begin
        check("ready_in_done", rdy3, 0);
        if (!seen) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = q.pop_front();
            check("bin", bin3, e.bin);
            check("err", err3, e.err);
            check("latency", cyc - e.acc, W3);
          end
          held     = bin3;
          held_err = err3;
          seen     = 1'b1;
        end else begin
          check("hold_bin", bin3, held);
          check("hold_err", err3, held_err);
        end
      end else begin
        seen = 1'b0;
        check("ready", rdy3, q.size() == 0);
        check("busy", busy3, q.size() != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) ir3 = ($urandom % 3) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int a, a1, a2;
    logic [11:0] r;
    bcd3 = '0; v3 = 1'b0; ir3 = 1'b1;
    bcd4 = '0; v4 = 1'b0; ir4 = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bin", bin3, 0);
    check("rst_err", err3, 0);
    check("rst_valid", ov3, 0);
    check("rst_busy", busy3, 0);
    check("rst_ready", rdy3, 1);
    rst = 1'b0;

    send3(12'h999, a); drop3(); drain3();
    send3(12'h000, a); drop3(); drain3();
    send3(12'h001, a); drop3(); drain3();
    send3(12'h500, a); drop3(); drain3();
    send3(12'h1A3, a); drop3(); drain3();
    send3(12'h123, a); drop3(); drain3();

    // Backpressure: result must hold while a new operand waits upstream.
    ir3 = 1'b0;
    send3(12'h456, a); drop3();
    fork
      send3(12'h789, a1);
      begin
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
          @(negedge clk);
          if (ov3) ok = 1'b1;
        end
        if (!ok) check("bp_valid_timeout", 0, 1);
        for (int i = 0; i < 7; i++) begin
          check("bp_valid", ov3, 1);
          check("bp_ready", rdy3, 0);
          @(negedge clk);
        end
        ir3 = 1'b1;
      end
    join
    drop3(); drain3();

    send3(12'h123, a1);
    send3(12'h456, a2);
    drop3();
    check("b2b_spacing", a2 - a1, W3 + 2);
    drain3();

    // Asynchronous reset partway through a conversion.
    send3(12'h999, a); drop3();
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    #1;
    check("arst_bin", bin3, 0);
    check("arst_err", err3, 0);
    check("arst_valid", ov3, 0);
    check("arst_busy", busy3, 0);
    check("arst_ready", rdy3, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send3(12'h042, a); drop3(); drain3();

    rand_bp = 1'b1;
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 3; k++) begin
        r[4*k +: 4] = (($urandom % 8) == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
      end
      send3(r, a);
      if (($urandom % 2) == 0) drop3();
    end
    drop3();
    drain3();
    rand_bp = 1'b0;
    ir3 = 1'b1;
    drain3();

    run4(16'h9999);
    run4(16'h0000);
    run4(16'h1234);
    run4(16'h9A00);
    for (int n = 0; n < 4; n++) begin
      run4({4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
